// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared period/prescaler, edge or center alignment and
// double-buffered config. Optional per-channel phase offset when PWM_PHASE_EN is defined.
module pwm_multi #(
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 10,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          update,
  input  logic [CNT_WIDTH-1:0]          period,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic                          center_aligned,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   duty,
`ifdef PWM_PHASE_EN
  input  logic [NUM_CH*CNT_WIDTH-1:0]   phase,
`endif
  input  logic [NUM_CH-1:0]             active_high,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic                          period_start,
  output logic                          update_pending
);

  logic [PRESCALE_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        dir_down_q, dir_down_d;

  logic [CNT_WIDTH-1:0]        period_act_q, period_act_d;
  logic [PRESCALE_WIDTH-1:0]   prescale_act_q, prescale_act_d;
  logic                        center_act_q, center_act_d;
  logic [NUM_CH*CNT_WIDTH-1:0] duty_act_q, duty_act_d;

  logic [CNT_WIDTH-1:0]        period_pend_q, period_pend_d;
  logic [PRESCALE_WIDTH-1:0]   prescale_pend_q, prescale_pend_d;
  logic                        center_pend_q, center_pend_d;
  logic [NUM_CH*CNT_WIDTH-1:0] duty_pend_q, duty_pend_d;

`ifdef PWM_PHASE_EN
  logic [NUM_CH*CNT_WIDTH-1:0] phase_act_q, phase_act_d;
  logic [NUM_CH*CNT_WIDTH-1:0] phase_pend_q, phase_pend_d;
`endif

  logic                        update_pending_q, update_pending_d;
  logic                        update_prev_q;
  logic [NUM_CH-1:0]           pwm_q, pwm_d;
  logic                        period_start_q, period_start_d;

  logic                        update_edge;
  logic                        tick;
  logic                        period_zero;
  logic [CNT_WIDTH-1:0]        period_m1;
  logic                        at_top;
  logic                        period_end;
  logic                        apply_pending;
  logic [CNT_WIDTH-1:0]        cmp_val [NUM_CH];

  assign update_edge   = update & ~update_prev_q;
  assign tick          = enable && (pre_cnt_q == prescale_act_q);
  assign period_zero   = (period_act_q == '0);
  assign period_m1     = period_act_q - CNT_WIDTH'(1);
  assign at_top        = (cnt_q == period_m1);
  // With P==0 every tick counts as a period end so a pending config can always land.
  assign period_end    = tick && (period_zero ||
                                  (center_act_q ? (dir_down_q && (cnt_q == '0)) : at_top));
  assign apply_pending = period_end && update_pending_q;

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    if (!enable) begin
      pre_cnt_d  = '0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else if (tick) begin
      pre_cnt_d = '0;
      if (period_zero) begin
        cnt_d      = '0;
        dir_down_d = 1'b0;
      end else if (!center_act_q) begin
        cnt_d      = at_top ? '0 : cnt_q + CNT_WIDTH'(1);
        dir_down_d = 1'b0;
      end else if (!dir_down_q) begin
        // Top value is visited twice: hold the count and only flip direction.
        if (at_top) dir_down_d = 1'b1;
        else        cnt_d      = cnt_q + CNT_WIDTH'(1);
      end else begin
        if (cnt_q == '0) dir_down_d = 1'b0;
        else             cnt_d      = cnt_q - CNT_WIDTH'(1);
      end
      if (apply_pending) begin
        cnt_d      = '0;
        dir_down_d = 1'b0;
      end
    end else begin
      pre_cnt_d = pre_cnt_q + PRESCALE_WIDTH'(1);
    end
  end

  always_comb begin
    period_act_d     = period_act_q;
    prescale_act_d   = prescale_act_q;
    center_act_d     = center_act_q;
    duty_act_d       = duty_act_q;
    period_pend_d    = period_pend_q;
    prescale_pend_d  = prescale_pend_q;
    center_pend_d    = center_pend_q;
    duty_pend_d      = duty_pend_q;
`ifdef PWM_PHASE_EN
    phase_act_d      = phase_act_q;
    phase_pend_d     = phase_pend_q;
`endif
    update_pending_d = update_pending_q;
    if (apply_pending) begin
      period_act_d     = period_pend_q;
      prescale_act_d   = prescale_pend_q;
      center_act_d     = center_pend_q;
      duty_act_d       = duty_pend_q;
`ifdef PWM_PHASE_EN
      phase_act_d      = phase_pend_q;
`endif
      update_pending_d = 1'b0;
    end
    // Capture after the transfer so a coincident edge stays pending for the next period.
    if (update_edge) begin
      period_pend_d    = period;
      prescale_pend_d  = prescale;
      center_pend_d    = center_aligned;
      duty_pend_d      = duty;
`ifdef PWM_PHASE_EN
      phase_pend_d     = phase;
`endif
      update_pending_d = 1'b1;
    end
  end

`ifdef PWM_PHASE_EN
  logic [CNT_WIDTH-1:0] phase_mod;
  logic [CNT_WIDTH:0]   phase_sum;

  always_comb begin
    phase_mod = '0;
    phase_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_val[i] = cnt_q;
      if (!center_act_q && !period_zero) begin
        phase_mod = phase_act_q[i*CNT_WIDTH +: CNT_WIDTH] % period_act_q;
        phase_sum = {1'b0, cnt_q} + {1'b0, phase_mod};
        if (phase_sum >= {1'b0, period_act_q}) phase_sum = phase_sum - {1'b0, period_act_q};
        cmp_val[i] = phase_sum[CNT_WIDTH-1:0];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) cmp_val[i] = cnt_q;
  end
`endif

  always_comb begin
    pwm_d = pwm_q;
    if (!enable) begin
      pwm_d = ~active_high;
    end else if (tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_d[i] = (!period_zero && (cmp_val[i] < duty_act_q[i*CNT_WIDTH +: CNT_WIDTH]))
                   ? active_high[i] : ~active_high[i];
      end
    end
    period_start_d = period_end;
  end

  always_ff @(posedge clk) begin
    // Tracking update through reset keeps a level held across reset from reading as an edge.
    update_prev_q <= update;
    if (reset) begin
      pre_cnt_q        <= '0;
      cnt_q            <= '0;
      dir_down_q       <= 1'b0;
      period_act_q     <= '0;
      prescale_act_q   <= '0;
      center_act_q     <= 1'b0;
      duty_act_q       <= '0;
      period_pend_q    <= '0;
      prescale_pend_q  <= '0;
      center_pend_q    <= 1'b0;
      duty_pend_q      <= '0;
`ifdef PWM_PHASE_EN
      phase_act_q      <= '0;
      phase_pend_q     <= '0;
`endif
      update_pending_q <= 1'b0;
      pwm_q            <= '0;
      period_start_q   <= 1'b0;
    end else begin
      pre_cnt_q        <= pre_cnt_d;
      cnt_q            <= cnt_d;
      dir_down_q       <= dir_down_d;
      period_act_q     <= period_act_d;
      prescale_act_q   <= prescale_act_d;
      center_act_q     <= center_act_d;
      duty_act_q       <= duty_act_d;
      period_pend_q    <= period_pend_d;
      prescale_pend_q  <= prescale_pend_d;
      center_pend_q    <= center_pend_d;
      duty_pend_q      <= duty_pend_d;
`ifdef PWM_PHASE_EN
      phase_act_q      <= phase_act_d;
      phase_pend_q     <= phase_pend_d;
`endif
      update_pending_q <= update_pending_d;
      pwm_q            <= pwm_d;
      period_start_q   <= period_start_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_start   = period_start_q;
  assign update_pending = update_pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized traffic against a
// period-position model. Define PWM_PHASE_EN to exercise the phase port.
module tb_pwm_multi;
  localparam int NCH = 4;
  localparam int CW  = 10;
  localparam int PW  = 8;

  logic              clk = 1'b0;
  logic              reset, enable, update, center_aligned;
  logic [CW-1:0]     period;
  logic [PW-1:0]     prescale;
  logic [NCH*CW-1:0] duty;
`ifdef PWM_PHASE_EN
  logic [NCH*CW-1:0] phase;
`endif
  logic [NCH-1:0]    active_high, pwm_out;
  logic              period_start, update_pending;

  always #5 clk = ~clk;

  pwm_multi #(.NUM_CH(NCH), .CNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .update(update),
    .period(period), .prescale(prescale), .center_aligned(center_aligned),
    .duty(duty),
`ifdef PWM_PHASE_EN
    .phase(phase),
`endif
    .active_high(active_high), .pwm_out(pwm_out),
    .period_start(period_start), .update_pending(update_pending));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Model: position t within the period; count value derived arithmetically from t.
  int a_per, a_pre, p_per, p_pre;
  bit a_ctr, p_ctr, p_flag, m_prev;
  int a_duty[NCH], p_duty[NCH], a_ph[NCH], p_ph[NCH];
  int m_c, m_t;
  logic [NCH-1:0] m_pwm;
  bit m_ps;

  always @(posedge clk) begin : model
    bit edge_d, tick;
    int len, cv, pos;
    if (reset) begin
      a_per = 0; a_pre = 0; a_ctr = 0; p_per = 0; p_pre = 0; p_ctr = 0; p_flag = 0;
      for (int i = 0; i < NCH; i++) begin
        a_duty[i] = 0; p_duty[i] = 0; a_ph[i] = 0; p_ph[i] = 0;
      end
      m_c = 0; m_t = 0; m_pwm = '0; m_ps = 0;
      m_prev = update;
    end else begin
      edge_d = update && !m_prev;
      m_prev = update;
      m_ps = 0;
      if (!enable) begin
        m_c = 0; m_t = 0; m_pwm = ~active_high;
      end else begin
        tick = (m_c == a_pre);
        m_c = tick ? 0 : m_c + 1;
        if (tick) begin
          len = (a_per == 0) ? 1 : (a_ctr ? 2 * a_per : a_per);
          cv  = (a_per == 0) ? 0 : ((a_ctr && m_t >= a_per) ? 2 * a_per - 1 - m_t : m_t);
          for (int i = 0; i < NCH; i++) begin
            pos = cv;
`ifdef PWM_PHASE_EN
            if (!a_ctr && a_per != 0) pos = (cv + a_ph[i]) % a_per;
`endif
            m_pwm[i] = (a_per != 0 && pos < a_duty[i]) ? active_high[i] : ~active_high[i];
          end
          if (m_t == len - 1) begin
            m_ps = 1; m_t = 0;
            if (p_flag) begin
              a_per = p_per; a_pre = p_pre; a_ctr = p_ctr; p_flag = 0;
              for (int i = 0; i < NCH; i++) begin a_duty[i] = p_duty[i]; a_ph[i] = p_ph[i]; end
            end
          end else begin
            m_t = m_t + 1;
          end
        end
      end
      if (edge_d) begin
        p_per = int'(period); p_pre = int'(prescale); p_ctr = center_aligned; p_flag = 1;
        for (int i = 0; i < NCH; i++) begin
          p_duty[i] = int'(duty[i*CW +: CW]);
`ifdef PWM_PHASE_EN
          p_ph[i] = int'(phase[i*CW +: CW]);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if (pwm_out !== m_pwm) begin
        n_fail++;
        $display("FAIL model_pwm t=%0t got %b expected %b", $time, pwm_out, m_pwm);
      end
      n_chk++;
      if (period_start !== m_ps) begin
        n_fail++;
        $display("FAIL model_period_start t=%0t got %b expected %b", $time, period_start, m_ps);
      end
      n_chk++;
      if (update_pending !== p_flag) begin
        n_fail++;
        $display("FAIL model_pending t=%0t got %b expected %b", $time, update_pending, p_flag);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic set_cfg(input int p, input int pre, input bit ctr,
                         input int d0, input int d1, input int d2, input int d3);
    period = CW'(p); prescale = PW'(pre); center_aligned = ctr;
    duty[0*CW +: CW] = CW'(d0); duty[1*CW +: CW] = CW'(d1);
    duty[2*CW +: CW] = CW'(d2); duty[3*CW +: CW] = CW'(d3);
  endtask

  task automatic pulse_update();
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
    check("pending_after_update", int'(update_pending), 1);
  endtask

  task automatic wait_applied();
    int k = 0;
    while (update_pending && k < 4000) begin @(negedge clk); k++; end
    check("apply_timeout", int'(update_pending), 0);
  endtask

  task automatic wait_ps();
    int k = 0;
    @(negedge clk);
    while (!period_start && k < 4000) begin @(negedge clk); k++; end
    check("period_start_timeout", int'(period_start), 1);
  endtask

  int hi[NCH];
  int ps_cnt;
  task automatic measure(input int n);
    ps_cnt = 0;
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ps_cnt += int'(period_start);
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
    end
  endtask

  task automatic apply(input int p, input int pre, input bit ctr,
                       input int d0, input int d1, input int d2, input int d3);
    set_cfg(p, pre, ctr, d0, d1, d2, d3);
    pulse_update();
    wait_applied();
    wait_ps();
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; update = 1'b0; active_high = '1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
`ifdef PWM_PHASE_EN
    phase = '0;
`endif
    @(negedge clk);
    chk_on = 1;
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_pending", int'(update_pending), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b1;

    apply(10, 0, 0, 0, 3, 10, 12);
    measure(10);
    check("edge_ch0_high", hi[0], 0);
    check("edge_ch1_high", hi[1], 3);
    check("edge_ch2_high", hi[2], 10);
    check("edge_ch3_high", hi[3], 10);
    check("edge_period_starts", ps_cnt, 1);

    apply(8, 1, 1, 3, 3, 3, 3);
    measure(32);
    check("center_high", hi[0], 12);
    check("center_period_starts", ps_cnt, 1);

    apply(10, 1, 0, 3, 3, 3, 3);
    measure(20);
    check("glitch_old_high", hi[0], 6);
    repeat (5) @(negedge clk);
    set_cfg(10, 1, 0, 7, 7, 7, 7);
    pulse_update();
    repeat (3) @(negedge clk);
    check("glitch_still_pending", int'(update_pending), 1);
    wait_applied();
    wait_ps();
    measure(20);
    check("glitch_new_high", hi[0], 14);

    active_high = '0;
    apply(10, 0, 0, 4, 4, 4, 4);
    measure(10);
    check("polarity_high", hi[2], 6);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_inactive", int'(pwm_out), 15);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_cnt0_active", int'(pwm_out), 0);
    active_high = '1;

    apply(0, 0, 0, 5, 5, 5, 5);
    measure(10);
    check("p0_period_starts", ps_cnt, 10);
    check("p0_inactive", hi[0] + hi[1] + hi[2] + hi[3], 0);

    apply(10, 3, 0, 1, 1, 1, 1);
    set_cfg(10, 3, 0, 2, 2, 2, 2);
    pulse_update();
    set_cfg(10, 3, 0, 6, 6, 6, 6);
    pulse_update();
    wait_applied();
    wait_ps();
    measure(40);
    check("last_update_wins", hi[1], 24);

`ifdef PWM_PHASE_EN
    phase[1*CW +: CW] = CW'(5); phase[3*CW +: CW] = CW'(15);
    apply(10, 0, 0, 5, 5, 5, 5);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pwm_out[1] == pwm_out[0]) n++;
    end
    check("phase_complement_agree", n, 0);
    measure(10);
    check("phase_mod_ch3", hi[3], 5);
`endif

    set_cfg(7, 0, 0, 3, 3, 3, 3);
    pulse_update();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_pwm", int'(pwm_out), 0);
    check("midreset_pending", int'(update_pending), 0);
    reset = 1'b0;

    for (int r = 0; r < 250; r++) begin
      @(negedge clk);
      set_cfg($urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 14), $urandom_range(0, 14),
              $urandom_range(0, 14), $urandom_range(0, 14));
`ifdef PWM_PHASE_EN
      for (int i = 0; i < NCH; i++) phase[i*CW +: CW] = CW'($urandom_range(0, 20));
`endif
      if ($urandom_range(0, 2) != 0) pulse_update();
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) active_high = NCH'($urandom);
        if ($urandom_range(0, 60) == 0) enable = ~enable;
        else if (!enable && $urandom_range(0, 5) == 0) enable = 1'b1;
        reset = ($urandom_range(0, 200) == 0);
        if ($urandom_range(0, 50) == 0) update = ~update;
      end
      update = 1'b0; reset = 1'b0; enable = 1'b1;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
